// File: rtl/regfile_read_arbiter.sv
// regfile_read_arbiter
//   Round-robin arbiter sharing the single synchronous read port of a
//   16-entry register file among NREQ requesters. Responses return on one
//   shared valid/ready channel tagged with the requester index, in grant order.
//   R0 is hardwired to zero: R0 reads never enable the port and return 0.
//
// Optional feature (macro REGFILE_READ_BYPASS_EN):
//   Adds an RF write-port snoop (wr_en/wr_addr/wr_data). A write to the
//   register being read, seen in the grant cycle or the following cycle,
//   replaces the stale RF data; the most recent write wins.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   req_valid[NREQ]     per-requester request valid
//   req_id[NREQ*AW]     packed register ids, requester i at [i*AW +: AW]
//   req_ready[NREQ]     grant, one-hot or zero
//   rf_rd_en, rf_rd_addr  register file read port
//   rf_rd_data          read data, valid the cycle after rf_rd_en
//   rsp_valid/rsp_ready response handshake
//   rsp_src, rsp_data   owner index and data of the response
//   wr_en/wr_addr/wr_data  RF write snoop (REGFILE_READ_BYPASS_EN only)
module regfile_read_arbiter #(
  parameter int NREQ = 4,
  parameter int DW   = 16,
  parameter int AW   = 4,
  parameter int SW   = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*AW-1:0] req_id,
  output logic [NREQ-1:0]    req_ready,
  output logic               rf_rd_en,
  output logic [AW-1:0]      rf_rd_addr,
  input  logic [DW-1:0]      rf_rd_data,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [SW-1:0]      rsp_src,
  output logic [DW-1:0]      rsp_data
`ifdef REGFILE_READ_BYPASS_EN
  ,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [DW-1:0]      wr_data
`endif
);

  localparam int unsigned NR = NREQ;

  // Arbitration state
  logic [SW-1:0] r_rr_ptr;

  // Stage S1: read in flight, RF data arrives this cycle
  logic          r_s1_valid;
  logic [SW-1:0] r_s1_src;
  logic          r_s1_zero;
`ifdef REGFILE_READ_BYPASS_EN
  logic [AW-1:0] r_s1_addr;
  logic          r_s1_byp;
  logic [DW-1:0] r_s1_byp_data;
`endif

  // Skid register, absorbs the one read in flight when the output stalls
  logic          r_skid_valid;
  logic [SW-1:0] r_skid_src;
  logic [DW-1:0] r_skid_data;

  // Output register
  logic          r_rsp_valid;
  logic [SW-1:0] r_rsp_src;
  logic [DW-1:0] r_rsp_data;

  // Combinational arbitration signals
  logic          w_hi_found;
  logic          w_lo_found;
  logic [SW-1:0] w_hi_idx;
  logic [SW-1:0] w_lo_idx;
  logic [SW-1:0] w_win;
  logic          w_any;
  logic [AW-1:0] w_win_id;
  logic          w_can_grant;
  logic          w_grant;
  logic [SW-1:0] w_rr_next;
  logic [NREQ-1:0] w_req_ready;
  logic          w_out_free;
  logic [DW-1:0] w_s1_data;

  // Round-robin winner: the lowest requester at or above rr_ptr wins;
  // if none, wrap to the lowest requester overall. Equivalent to scanning
  // rr_ptr, rr_ptr+1, ... modulo NREQ.
  always_comb begin
    w_hi_found = 1'b0;
    w_lo_found = 1'b0;
    w_hi_idx   = '0;
    w_lo_idx   = '0;
    for (int unsigned i = 0; i < NR; i++) begin
      if (req_valid[i]) begin
        if (!w_lo_found) begin
          w_lo_found = 1'b1;
          w_lo_idx   = SW'(i);
        end
        if (!w_hi_found && (SW'(i) >= r_rr_ptr)) begin
          w_hi_found = 1'b1;
          w_hi_idx   = SW'(i);
        end
      end
    end
    w_any = w_lo_found;
    w_win = w_hi_found ? w_hi_idx : w_lo_idx;
  end

  always_comb begin
    w_win_id = '0;
    for (int unsigned i = 0; i < NR; i++) begin
      if (w_win == SW'(i)) begin
        w_win_id = req_id[i*AW +: AW];
      end
    end
  end

  // Grants stop while the skid holds data or the output is stalled, so at
  // most one read (the one already in S1) can land in skid.
  always_comb begin
    w_can_grant = !r_skid_valid && !(r_rsp_valid && !rsp_ready);
    w_grant     = rst_n && w_can_grant && w_any;
    w_rr_next   = (w_win == SW'(NREQ - 1)) ? '0 : w_win + SW'(1);
    w_out_free  = !r_rsp_valid || rsp_ready;
    for (int unsigned i = 0; i < NR; i++) begin
      w_req_ready[i] = w_grant && (w_win == SW'(i));
    end
  end

  assign req_ready  = w_req_ready;
  assign rf_rd_en   = w_grant && (w_win_id != '0);
  assign rf_rd_addr = w_grant ? w_win_id : '0;

  // S1 data select
`ifdef REGFILE_READ_BYPASS_EN
  // A write in this cycle is newer than one captured at grant time.
  always_comb begin
    w_s1_data = rf_rd_data;
    if (r_s1_zero) begin
      w_s1_data = '0;
    end else if (wr_en && (wr_addr == r_s1_addr)) begin
      w_s1_data = wr_data;
    end else if (r_s1_byp) begin
      w_s1_data = r_s1_byp_data;
    end
  end
`else
  always_comb begin
    w_s1_data = r_s1_zero ? '0 : rf_rd_data;
  end
`endif

  // Grant capture into S1
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rr_ptr   <= '0;
      r_s1_valid <= 1'b0;
      r_s1_src   <= '0;
      r_s1_zero  <= 1'b0;
    end else begin
      r_s1_valid <= w_grant;
      if (w_grant) begin
        r_rr_ptr  <= w_rr_next;
        r_s1_src  <= w_win;
        r_s1_zero <= (w_win_id == '0);
      end
    end
  end

`ifdef REGFILE_READ_BYPASS_EN
  // Write seen in the grant cycle; the RF read issued that cycle is stale.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_addr     <= '0;
      r_s1_byp      <= 1'b0;
      r_s1_byp_data <= '0;
    end else if (w_grant) begin
      r_s1_addr     <= w_win_id;
      r_s1_byp      <= wr_en && (wr_addr == w_win_id) && (w_win_id != '0);
      r_s1_byp_data <= wr_data;
    end
  end
`endif

  // Output register and skid. Skid always drains before S1 to keep
  // responses in grant order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_skid_valid <= 1'b0;
      r_skid_src   <= '0;
      r_skid_data  <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_src    <= '0;
      r_rsp_data   <= '0;
    end else if (w_out_free) begin
      if (r_skid_valid) begin
        r_rsp_valid  <= 1'b1;
        r_rsp_src    <= r_skid_src;
        r_rsp_data   <= r_skid_data;
        r_skid_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_skid_src  <= r_s1_src;
          r_skid_data <= w_s1_data;
        end
      end else if (r_s1_valid) begin
        r_rsp_valid <= 1'b1;
        r_rsp_src   <= r_s1_src;
        r_rsp_data  <= w_s1_data;
      end else begin
        r_rsp_valid <= 1'b0;
      end
    end else if (r_s1_valid) begin
      r_skid_valid <= 1'b1;
      r_skid_src   <= r_s1_src;
      r_skid_data  <= w_s1_data;
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_src   = r_rsp_src;
  assign rsp_data  = r_rsp_data;

`ifndef SYNTHESIS
  a_ready_onehot : assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(req_ready));
  a_skid_no_overwrite : assert property (@(posedge clk) disable iff (!rst_n)
    !(r_skid_valid && !w_out_free && r_s1_valid));
`endif

endmodule
